// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter onto a single picorv32-native memory port.
// One transaction in flight at a time; target stalls end in a watchdog timeout.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;

    logic             win_c;
    req_t             win_req_c;
    logic             tmo_c;
    logic             done_c;
    logic [31:0]      rsp_data_c;

    // Round-robin pick: on a tie the requester that did not go last wins.
    always_comb begin
        win_c = m1_valid;
        if (m0_valid && m1_valid) begin
            win_c = ~last_grant;
        end
        win_req_c = win_c ? req_t'{m1_instr, m1_addr, m1_wdata, m1_wstrb}
                          : req_t'{m0_instr, m0_addr, m0_wdata, m0_wstrb};
    end

    // Completion source: target ready has priority over the watchdog.
    always_comb begin
        tmo_c      = TMO_EN && (cnt == CNT_LAST) && !s_ready;
        done_c     = s_ready || tmo_c;
        rsp_data_c = s_ready ? s_rdata : TIMEOUT_DATA;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            cnt         <= '0;
            s_valid     <= 1'b0;
            s_instr     <= 1'b0;
            s_addr      <= '0;
            s_wdata     <= '0;
            s_wstrb     <= '0;
            grant       <= '0;
            timeout_err <= 1'b0;
            m0_ready    <= 1'b0;
            m0_rdata    <= '0;
            m1_ready    <= 1'b0;
            m1_rdata    <= '0;
        end else begin
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        s_valid    <= 1'b1;
                        s_instr    <= win_req_c.instr;
                        s_addr     <= win_req_c.addr;
                        s_wdata    <= win_req_c.wdata;
                        s_wstrb    <= win_req_c.wstrb;
                        grant      <= win_c ? 2'b10 : 2'b01;
                        last_grant <= win_c;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (done_c) begin
                        s_valid     <= 1'b0;
                        timeout_err <= tmo_c;
                        state       <= RESP;
                        if (grant[1]) begin
                            m1_ready <= 1'b1;
                            m1_rdata <= rsp_data_c;
                        end else begin
                            m0_ready <= 1'b1;
                            m0_rdata <= rsp_data_c;
                        end
                    end
                end
                RESP: begin
                    // Requester still shows valid here, so no arbitration this cycle.
                    cnt   <= '0;
                    grant <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: requester drivers, a target model with
// programmable response delay, and an independent round-robin prediction.
module tb_mem_bus_arbiter;

    localparam int unsigned TMO = 16;

    typedef struct {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          delay;
        logic [31:0] rdata;
        logic        tmo;
    } req_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_valid = 1'b0, m0_instr = 1'b0, m0_ready;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m0_rdata;
    logic [3:0]  m0_wstrb = '0;
    logic        m1_valid = 1'b0, m1_instr = 1'b0, m1_ready;
    logic [31:0] m1_addr = '0, m1_wdata = '0, m1_rdata;
    logic [3:0]  m1_wstrb = '0;
    logic        s_valid, s_instr;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  grant;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    req_t rq0[$], rq1[$];
    req_t sb0[$], sb1[$];
    bit   act0 = 0, act1 = 0, got0 = 0, got1 = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES(TMO),
        .TIMEOUT_DATA  (32'hDEADBEEF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_valid   (m0_valid),
        .m0_instr   (m0_instr),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_wstrb   (m0_wstrb),
        .m0_ready   (m0_ready),
        .m0_rdata   (m0_rdata),
        .m1_valid   (m1_valid),
        .m1_instr   (m1_instr),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_wstrb   (m1_wstrb),
        .m1_ready   (m1_ready),
        .m1_rdata   (m1_rdata),
        .s_valid    (s_valid),
        .s_instr    (s_instr),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_ready    (s_ready),
        .s_rdata    (s_rdata),
        .grant      (grant),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] tgt_data(input logic [31:0] a);
        return a ^ 32'h1234_5340;
    endfunction

    // Queue a request and its expected outcome; delay <1 means the target never answers.
    task automatic add_req(input int r, input logic instr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb, input int delay);
        req_t q;
        q.instr = instr;
        q.addr  = addr;
        q.wdata = wdata;
        q.wstrb = wstrb;
        q.delay = delay;
        q.tmo   = (delay < 1) || (delay > int'(TMO));
        q.rdata = q.tmo ? 32'hDEADBEEF : tgt_data(addr);
        if (r == 0) begin
            rq0.push_back(q);
            sb0.push_back(q);
        end else begin
            rq1.push_back(q);
            sb1.push_back(q);
        end
    endtask

    // One cycle of requester behaviour: hold valid through the ready cycle, then drop or reload.
    task automatic step();
        req_t q;
        @(posedge clk);
        #1;
        if (act0 && got0) begin
            act0 = 0; m0_valid = 1'b0; m0_addr = $urandom; m0_wdata = $urandom;
        end
        if (!act0 && rq0.size() > 0) begin
            q = rq0.pop_front();
            m0_valid = 1'b1; m0_instr = q.instr; m0_addr = q.addr;
            m0_wdata = q.wdata; m0_wstrb = q.wstrb; act0 = 1; got0 = 0;
        end
        if (act0 && m0_ready) got0 = 1;
        if (act1 && got1) begin
            act1 = 0; m1_valid = 1'b0; m1_addr = $urandom; m1_wdata = $urandom;
        end
        if (!act1 && rq1.size() > 0) begin
            q = rq1.pop_front();
            m1_valid = 1'b1; m1_instr = q.instr; m1_addr = q.addr;
            m1_wdata = q.wdata; m1_wstrb = q.wstrb; act1 = 1; got1 = 0;
        end
        if (act1 && m1_ready) got1 = 1;
    endtask

    task automatic run(input int max);
        bit idle;
        idle = 0;
        for (int i = 0; i < max; i++) begin
            idle = (rq0.size() == 0) && (rq1.size() == 0) && !act0 && !act1;
            if (idle) break;
            step();
        end
        idle = (rq0.size() == 0) && (rq1.size() == 0) && !act0 && !act1;
        check("run_done", 32'(idle), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m0_valid = 1'b0; m1_valid = 1'b0;
        act0 = 0; act1 = 0; got0 = 0; got1 = 0;
        rq0.delete(); rq1.delete(); sb0.delete(); sb1.delete();
        step();
        reset = 1'b0;
    endtask

    // Target model, arbitration prediction and output checks.
    bit          r_neg = 1'b1;
    bit          sv_q = 1'b0, v0p = 1'b0, v1p = 1'b0, mlast = 1'b1, win;
    bit          cur_valid = 1'b0;
    req_t        cur;
    logic [1:0]  cur_gnt = '0;
    int          cyc = 0, rise_cyc = 0, busy = 0, last_busy = 0, exp_len;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (r_neg) begin
                mlast = 1'b1; cur_valid = 1'b0; sv_q = 1'b0; busy = 0;
            end else if (s_valid && !sv_q) begin
                check("arb_had_req", 32'(v0p || v1p), 32'd1);
                win = (v0p && v1p) ? !mlast : v1p;
                mlast = win;
                cur_gnt = win ? 2'b10 : 2'b01;
                cur_valid = 1'b0;
                if (win && sb1.size() > 0) begin
                    cur = sb1.pop_front(); cur_valid = 1'b1;
                end else if (!win && sb0.size() > 0) begin
                    cur = sb0.pop_front(); cur_valid = 1'b1;
                end
                check("sb_has_item", 32'(cur_valid), 32'd1);
                if (cur_valid) begin
                    rise_cyc = cyc;
                    check("grant_busy", 32'(grant), 32'(cur_gnt));
                    check("s_addr", s_addr, cur.addr);
                    check("s_wdata", s_wdata, cur.wdata);
                    check("s_wstrb", 32'(s_wstrb), 32'(cur.wstrb));
                    check("s_instr", 32'(s_instr), 32'(cur.instr));
                end
            end
            sv_q = s_valid;
            if (s_valid) begin
                busy++;
                last_busy = busy;
                s_ready = cur_valid && (busy == cur.delay);
                s_rdata = s_ready ? tgt_data(s_addr) : 32'($urandom);
            end else begin
                busy = 0;
                s_ready = 1'($urandom_range(0, 1));
                s_rdata = $urandom;
            end

            @(negedge clk);
            if (r_neg) begin
                check("rst_s_valid", 32'(s_valid), 32'd0);
                check("rst_grant", 32'(grant), 32'd0);
                check("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
                check("rst_timeout", 32'(timeout_err), 32'd0);
                check("rst_s_addr", s_addr | s_wdata | 32'(s_wstrb) | 32'(s_instr), 32'd0);
                check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
            end
            r_neg = reset;
            v0p = m0_valid;
            v1p = m1_valid;
            if (m0_ready || m1_ready) begin
                if (!cur_valid) begin
                    check("spurious_ready", 32'({m1_ready, m0_ready}), 32'd0);
                end else begin
                    exp_len = cur.tmo ? int'(TMO) : cur.delay;
                    check("ready_owner", 32'({m1_ready, m0_ready}), 32'(cur_gnt));
                    check("grant_resp", 32'(grant), 32'(cur_gnt));
                    check("rdata", cur_gnt[1] ? m1_rdata : m0_rdata, cur.rdata);
                    check("timeout_err", 32'(timeout_err), 32'(cur.tmo));
                    check("busy_len", 32'(last_busy), 32'(exp_len));
                    check("latency", 32'(cyc - rise_cyc), 32'(exp_len));
                    check("s_valid_resp", 32'(s_valid), 32'd0);
                    cur_valid = 1'b0;
                end
            end else begin
                if (timeout_err) check("stray_timeout", 32'(timeout_err), 32'd0);
                if (cur_valid) begin
                    check("s_valid_hold", 32'(s_valid), 32'd1);
                    check("s_addr_hold", s_addr, cur.addr);
                end
            end
        end
    end

    initial begin
        int w;
        repeat (3) step();
        reset = 1'b0;

        // Single core read; 0x538 maps to 0x12345678 in the target model.
        add_req(0, 1'b0, 32'h0000_0538, 32'h0, 4'h0, 2);
        check("t1_exp_data", sb0[0].rdata, 32'h1234_5678);
        run(50);

        // Simultaneous requests right after reset: m0 first, then m1 write.
        do_reset();
        add_req(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1);
        add_req(1, 1'b0, 32'h0000_8000, 32'hA5A5_A5A5, 4'hF, 1);
        run(50);

        // Continuous contention, 8 transactions, mixed target delays.
        for (int i = 0; i < 4; i++) begin
            add_req(0, 1'($urandom_range(0, 1)), 32'($urandom) & 32'hFFFF_FFFC,
                    32'($urandom), 4'($urandom), int'($urandom_range(1, 3)));
            add_req(1, 1'($urandom_range(0, 1)), 32'($urandom) & 32'hFFFF_FFFC,
                    32'($urandom), 4'($urandom), int'($urandom_range(1, 3)));
        end
        run(200);

        // Stalled target, then a normal follow-up.
        add_req(1, 1'b0, 32'h0000_2000, 32'h0, 4'h0, -1);
        run(60);
        add_req(0, 1'b1, 32'h0000_0040, 32'h0, 4'h0, 2);
        run(50);

        // Ready on the last allowed BUSY cycle, and one cycle earlier.
        add_req(1, 1'b0, 32'h0000_3000, 32'h0000_0011, 4'h3, 16);
        add_req(0, 1'b0, 32'h0000_3004, 32'h0, 4'h0, 15);
        run(100);

        // Reset while BUSY, then a tie must go to m0.
        add_req(0, 1'b0, 32'h0000_4000, 32'h0, 4'h0, -1);
        w = 0;
        while (!s_valid && w < 10) begin
            step();
            w++;
        end
        check("t6_busy_reached", 32'(s_valid), 32'd1);
        repeat (3) step();
        do_reset();
        add_req(0, 1'b0, 32'h0000_5000, 32'h0, 4'h0, 1);
        add_req(1, 1'b0, 32'h0000_6000, 32'h0, 4'h0, 1);
        run(50);

        repeat (3) step();
        check("sb_drained", 32'(sb0.size() + sb1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-requester arbiter sharing one picorv32-native memory port (valid/ready/addr/wdata/wstrb/rdata).
- Requester 0 is the CPU core side; requester 1 is the Ethernet DMA engine.
- Sits between the core-side address mux and memory_module: one transaction at a time, round-robin fairness, registered request/response paths, and a watchdog timeout for a stalled target.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles in BUSY waiting for s_ready; 0 disables the timeout.
- TIMEOUT_DATA, 32'hDEADBEEF: rdata returned to the requester on timeout.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- m0_valid  in  1  core request valid; held until m0_ready
- m0_instr  in  1  instruction-fetch flag
- m0_addr  in  32  byte address
- m0_wdata  in  32  write data
- m0_wstrb  in  4  byte strobes; 0 = read
- m0_ready  out  1  one-cycle completion pulse to core
- m0_rdata  out  32  read data, valid while m0_ready=1
- m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as m0_*, for the DMA requester
- s_valid  out  1  downstream request valid
- s_instr  out  1  latched instr flag
- s_addr  out  32  latched address
- s_wdata  out  32  latched write data
- s_wstrb  out  4  latched strobes
- s_ready  in  1  downstream completion
- s_rdata  in  32  downstream read data
- grant  out  2  one-hot owner of the current transaction; 0 when idle
- timeout_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset values: all outputs 0; state=IDLE; last_grant=1, so m0 wins the first tie; timeout counter=0.
- Reset asserted mid-transaction aborts it: s_valid drops the next cycle and no ready pulse is issued.
- State IDLE:
  - If any mX_valid: pick a winner. Single requester wins directly. If both, the requester that is not last_grant wins.
  - Latch the winner's instr/addr/wdata/wstrb into s_*; set s_valid=1, grant to the winner's one-hot, last_grant=winner; go to BUSY.
  - Request sampled in cycle N gives s_valid=1 in cycle N+1.
- State BUSY:
  - s_* stay stable and s_valid stays 1; the counter increments each cycle.
  - If s_ready=1: capture s_rdata, s_valid=0, go to RESP.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: capture TIMEOUT_DATA, s_valid=0, timeout_err=1 for one cycle, go to RESP.
  - s_ready in the same cycle as the timeout limit: ready wins, no error.
  - Requester inputs are ignored in BUSY; dropping mX_valid does not abort the transaction.
- State RESP (exactly one cycle):
  - Granted mX_ready=1 with mX_rdata=captured data; the other requester's ready stays 0.
  - Counter cleared; go to IDLE with grant=0.
  - No arbitration in RESP, because the requester still shows valid in this cycle.
- Latency: s_ready in cycle M gives mX_ready in cycle M+1. Minimum transaction is 3 cycles from mX_valid to mX_ready for a single-cycle target. Next arbitration happens at M+2.
- mX_rdata holds its last value outside the ready pulse; it is only meaningful with ready.
- Write transactions return rdata as driven by the target; requesters ignore it.
- s_ready asserted while not in BUSY is ignored.

Test Plan:
- Single core read: m0_valid addr=0x0000_0538 wstrb=0, target s_ready one cycle after s_valid with rdata=0x1234_5678 -> s_addr=0x538 at N+1; m0_ready=1 and m0_rdata=0x12345678 at N+3; grant=01 during BUSY/RESP; m1_ready stays 0.
- Simultaneous requests after reset: m0 and m1 both valid, m1 addr=0x0000_8000 wstrb=4'hF wdata=0xA5A5_A5A5 -> m0 served first, then m1 with s_wstrb=F and s_wdata=A5A5A5A5; grant sequence 01 then 10.
- Continuous contention for 8 transactions -> grant strictly alternates 01,10,01,…; neither requester starves; each ready goes only to the owner.
- Target stall: TIMEOUT_CYCLES=16, s_ready never asserted -> s_valid drops after 16 BUSY cycles; timeout_err pulses once; m1_ready=1 with rdata=0xDEADBEEF; next request is arbitrated normally.
- Boundary: s_ready arrives exactly on cycle 16 of BUSY -> normal completion with target data; timeout_err=0.
- Reset in BUSY: assert reset with s_valid=1 -> next cycle all outputs 0 and grant=0; no mX_ready pulse; after release, m0 wins a tie.
